decrypt_round_iter: RTL and testbench

Iterative AES-128 decryption core, the inverse counterpart of the encryption round datapath. Accepts one 128-bit ciphertext block over a valid/ready handshake and runs the initial AddRoundKey, nine full inverse rounds and the inverse final round. The inverse final round is InvShiftRows, InvSubBytes and AddRoundKey with no InvMixColumns. The core performs one round per clock, fetches round keys by index from an external key store, and returns plaintext over a second valid/ready handshake.

---
 rtl/decrypt_round_iter.sv | 168 ++++++++++++++++
 tb/tb_decrypt_round_iter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decrypt_round_iter.sv
// decrypt_round_iter: iterative AES-128 decryption core, one inverse round per clock.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   in_valid    ciphertext present
//   in_ready    core can accept a block (high only while idle)
//   ciphertext  128-bit input block, byte 0 in [127:120], column-major
//   key_idx     index (0..10) of the round key needed this cycle
//   round_key   key for key_idx, looked up combinationally by the key store
//   out_valid   plaintext valid (registered)
//   out_ready   downstream accepts plaintext
//   plaintext   128-bit result (registered)
//
// Flow: the accept cycle applies round key 10, then ten ROUND cycles walk rnd 9..0.
// rnd 9..1 are full inverse rounds; rnd 0 is the final round without InvMixColumns.
module decrypt_round_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  output logic [3:0]   key_idx,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext
);

  typedef enum logic [1:0] {StIdle, StRound, StDone} fsm_e;

  // Inverse S-box, row-major: entry x sits at bits [2047-8x -: 8].
  localparam logic [2047:0] InvSboxTable = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // 2040 - 8x == 8 * (255 - x) == 8 * ~x, which keeps the index a clean 11 bits.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return InvSboxTable[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Returns {a*0e, a*0b, a*0d, a*09}.
  function automatic logic [31:0] inv_mul(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return {x8 ^ x4 ^ x2, x8 ^ x2 ^ a, x8 ^ x4 ^ a, x8 ^ a};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [31:0] p0, p1, p2, p3;
    p0 = inv_mul(col[31:24]);
    p1 = inv_mul(col[23:16]);
    p2 = inv_mul(col[15:8]);
    p3 = inv_mul(col[7:0]);
    // Slices: [31:24]=x0e, [23:16]=x0b, [15:8]=x0d, [7:0]=x09.
    return {p0[31:24] ^ p1[23:16] ^ p2[15:8]  ^ p3[7:0],
            p0[7:0]   ^ p1[31:24] ^ p2[23:16] ^ p3[15:8],
            p0[15:8]  ^ p1[7:0]   ^ p2[31:24] ^ p3[23:16],
            p0[23:16] ^ p1[15:8]  ^ p2[7:0]   ^ p3[31:24]};
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         out_valid_q, out_valid_d;
  logic [127:0] plaintext_q, plaintext_d;

  logic [127:0] round_t;   // InvSubBytes(InvShiftRows(state)) ^ round_key
  logic [127:0] round_mix; // InvMixColumns(round_t)

  // Byte i = r + 4c lives at [127-8i -: 8]. InvShiftRows moves row r right by r,
  // so output column c takes row r from input column (c - r) mod 4.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int unsigned Dst = r + 4 * c;
      localparam int unsigned Src = r + 4 * ((c + 4 - r) % 4);
      assign round_t[127-8*Dst -: 8] = inv_sbox(state_q[127-8*Src -: 8])
                                       ^ round_key[127-8*Dst -: 8];
    end
    assign round_mix[127-32*c -: 32] = inv_mix_col(round_t[127-32*c -: 32]);
  end

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    rnd_d       = rnd_q;
    out_valid_d = out_valid_q;
    plaintext_d = plaintext_q;
    in_ready    = 1'b0;
    key_idx     = 4'd10;

    case (fsm_q)
      StIdle: begin
        in_ready = 1'b1;
        key_idx  = 4'd10;
        if (in_valid) begin
          state_d = ciphertext ^ round_key;
          rnd_d   = 4'd9;
          fsm_d   = StRound;
        end
      end
      StRound: begin
        key_idx = rnd_q;
        if (rnd_q != 4'd0) begin
          state_d = round_mix;
          rnd_d   = rnd_q - 4'd1;
        end else begin
          state_d     = round_t;
          plaintext_d = round_t;
          out_valid_d = 1'b1;
          fsm_d       = StDone;
        end
      end
      StDone: begin
        key_idx = 4'd0;
        // A same-cycle in_valid is left for the following idle cycle.
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = StIdle;
        end
      end
      default: begin
        fsm_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q       <= StIdle;
      state_q     <= '0;
      rnd_q       <= '0;
      out_valid_q <= 1'b0;
      plaintext_q <= '0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      out_valid_q <= out_valid_d;
      plaintext_q <= plaintext_d;
    end
  end

  assign out_valid = out_valid_q;
  assign plaintext = plaintext_q;

endmodule

// File: tb/tb_decrypt_round_iter.sv
// Bench for decrypt_round_iter. The reference is an independent forward AES-128
// model: the S-box is derived from GF(2^8) inversion plus the affine map, round
// keys come from the bench's own key expansion, and model-generated vectors are
// produced by encrypting a known plaintext.
module tb_decrypt_round_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic [3:0]   key_idx;
  logic [127:0] round_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;

  logic [127:0] ks [11];
  logic [127:0] mk [11];
  logic [7:0]   sbox [256];

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [127:0] KeyC1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CtC1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PtC1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KeyB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CtB   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PtB   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [43:0]  KeySeq = 44'ha9876543210;

  always #5 clk = ~clk;

  assign round_key = (key_idx <= 4'd10) ? ks[key_idx] : '0;

  decrypt_round_iter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .key_idx    (key_idx),
    .round_key  (round_key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = 32'(key >> (32 * (3 - i)));
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]}
              ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Forward cipher using the round keys in mk.
  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] acc;
    acc = pt ^ mk[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox[8'(acc >> (8 * (15 - i)))];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) t[rw + 4*c] = s[rw + 4*((c + rw) % 4)];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      acc = '0;
      for (int i = 0; i < 16; i++) acc = (acc << 8) | {120'd0, t[i]};
      acc = acc ^ mk[r];
    end
    return acc;
  endfunction

  task automatic load_ks();
    for (int i = 0; i < 11; i++) ks[i] = mk[i];
  endtask

  // Called at a negedge with the core idle; returns at the negedge after the output handshake.
  task automatic run_block(input logic [127:0] ct, output logic [127:0] pt,
                           output int lat, output logic [43:0] seq);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    seq        = {40'd0, key_idx};
    in_valid   = 1'b1;
    ciphertext = ct;
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 40) begin
      seq = {seq[39:0], key_idx};
      @(negedge clk);
      lat++;
    end
    pt        = plaintext;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    bit           gen_ct;
    bit           zero_k0;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [127:0] got;
    logic [127:0] ct;
    logic [127:0] pt0;
    logic [127:0] outs [2];
    logic [43:0]  seq;
    int           lat;
    int           cyc;
    int           acc1;
    int           acc2;
    int           npt;
    int           seen;
    bit           swap_pend;
    bit           drop_pend;

    vecs[0] = '{KeyC1, CtC1, PtC1, 1'b0, 1'b0};
    vecs[1] = '{KeyB, CtB, PtB, 1'b0, 1'b0};
    vecs[2] = '{KeyC1, 128'd0, PtC1, 1'b1, 1'b1};
    vecs[3] = '{KeyB, 128'd0, 128'hdeadbeef0123456789abcdeffedcba98, 1'b1, 1'b1};
    vecs[4] = '{128'd0, 128'd0, 128'd0, 1'b1, 1'b0};
    vecs[5] = '{{128{1'b1}}, 128'd0, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 1'b1, 1'b0};

    build_sbox();
    expand(KeyC1);
    load_ks();

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    ciphertext = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    chk("reset_in_ready", {127'd0, in_ready}, 128'd1);
    chk("reset_key_idx", {124'd0, key_idx}, 128'd10);
    chk("reset_out_valid", {127'd0, out_valid}, 128'd0);
    chk("reset_plaintext", plaintext, 128'd0);

    // Directed vectors: FIPS-197 C.1 and B, then model-generated blocks
    // (several with round key 0 zeroed to isolate the final round).
    for (int v = 0; v < 6; v++) begin
      expand(vecs[v].key);
      if (vecs[v].zero_k0) mk[0] = '0;
      ct = vecs[v].gen_ct ? aes_enc(vecs[v].pt) : vecs[v].ct;
      load_ks();
      run_block(ct, got, lat, seq);
      chk($sformatf("vec%0d_plaintext", v), got, vecs[v].pt);
      chk($sformatf("vec%0d_latency", v), 128'(lat), 128'd11);
      chk($sformatf("vec%0d_key_idx_seq", v), {84'd0, seq}, {84'd0, KeySeq});
      chk($sformatf("vec%0d_idle_after", v), {127'd0, in_ready}, 128'd1);
    end

    // Backpressure: in_valid held high, out_ready low for 20 cycles.
    expand(KeyC1);
    load_ks();
    in_valid   = 1'b1;
    ciphertext = CtC1;
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    pt0 = plaintext;
    chk("bp_plaintext", pt0, PtC1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", i), {out_valid, in_ready, plaintext},
          {1'b1, 1'b0, PtC1});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_after_handshake", {126'd0, out_valid, in_ready}, 128'b01);
    @(negedge clk);
    chk("bp_second_accept", {123'd0, in_ready, key_idx}, {123'd0, 1'b0, 4'd9});
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_second_plaintext", plaintext, PtC1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Back-to-back: C.1 then B with out_ready high; key store swapped in DONE.
    expand(KeyC1);
    load_ks();
    in_valid   = 1'b1;
    ciphertext = CtC1;
    out_ready  = 1'b1;
    cyc = 0; acc1 = -1; acc2 = -1; npt = 0;
    swap_pend = 1'b0; drop_pend = 1'b0;
    outs[0] = '0; outs[1] = '0;
    while (cyc < 80 && (acc2 < 0 || npt < 2)) begin
      if (swap_pend) begin ciphertext = CtB; swap_pend = 1'b0; end
      if (drop_pend) begin in_valid = 1'b0; drop_pend = 1'b0; end
      if (in_valid && in_ready) begin
        if (acc1 < 0) begin acc1 = cyc; swap_pend = 1'b1; end
        else begin acc2 = cyc; drop_pend = 1'b1; end
      end
      if (out_valid) begin
        if (npt < 2) outs[npt] = plaintext;
        npt++;
        if (npt == 1) begin
          expand(KeyB);
          load_ks();
        end
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_accept_spacing", 128'(acc2 - acc1), 128'd12);
    chk("b2b_first_plaintext", outs[0], PtC1);
    chk("b2b_second_plaintext", outs[1], PtB);
    chk("b2b_output_count", 128'(npt), 128'd2);

    // Reset while rnd = 5, then a fresh block.
    expand(KeyC1);
    load_ks();
    in_valid   = 1'b1;
    ciphertext = CtC1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (key_idx != 4'd5 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_mid_plaintext", plaintext, 128'd0);
    chk("rst_mid_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_mid_key_idx", {124'd0, key_idx}, 128'd10);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_mid_no_output", 128'(seen), 128'd0);
    run_block(CtC1, got, lat, seq);
    chk("rst_mid_fresh_plaintext", got, PtC1);
    chk("rst_mid_fresh_latency", 128'(lat), 128'd11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
